// File: rtl/wb_pkg.sv
// Shared types and default sizing for the register-file writeback queue.
package wb_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_REG_W  = 4;
  localparam int WB_DATA_W = 16;

  // One pending register-file write. The register id cannot be called 'reg'.
  typedef struct packed {
    logic [WB_REG_W-1:0]  regId;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Producer handshakes (mem load, ALU) and the register-file write port of the writeback queue.
interface reg_writeback_queue_if
  import wb_pkg::*;
#(
  parameter int REG_W  = WB_REG_W,
  parameter int DATA_W = WB_DATA_W
);

  logic              mem_valid;
  logic [REG_W-1:0]  mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              alu_valid;
  logic [REG_W-1:0]  alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic [REG_W-1:0]  DstReg;
  logic [DATA_W-1:0] DstData;
  logic              WriteReg;

  modport master (
    output mem_valid, mem_reg, mem_data,
    input  mem_ready,
    output alu_valid, alu_reg, alu_data,
    input  alu_ready,
    input  DstReg, DstData, WriteReg
  );

  modport slave (
    input  mem_valid, mem_reg, mem_data,
    output mem_ready,
    input  alu_valid, alu_reg, alu_data,
    output alu_ready,
    output DstReg, DstData, WriteReg
  );

endinterface

// File: rtl/wb_fwd_match.sv
// Youngest-first search of the queued writes for one forwarding lookup port.
module wb_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int REG_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic [REG_W-1:0]  srcReg,
  input  logic [REG_W-1:0]  entReg  [DEPTH],
  input  logic [DATA_W-1:0] entData [DEPTH],
  input  logic [DEPTH-1:0]  entVld,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  // Entries are ordered oldest (0) to youngest, so the last match wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entVld[k] && (srcReg != '0) && (entReg[k] == srcReg)) begin
        hit  = 1'b1;
        data = entData[k];
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order writeback queue feeding the register file's single write port.
// Define WB_FWD_EN to add two forwarding lookup ports over the queued writes.
module reg_writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_W  = WB_REG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_writeback_queue_if.slave   wb,
  output logic [$clog2(DEPTH):0] count
`ifdef WB_FWD_EN
  ,
  input  logic [REG_W-1:0]       SrcReg1,
  input  logic [REG_W-1:0]       SrcReg2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DATA_W-1:0]      fwd_data1,
  output logic [DATA_W-1:0]      fwd_data2
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [REG_W-1:0]  regArr  [DEPTH];
  logic [DATA_W-1:0] dataArr [DEPTH];
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [PW-1:0]     aluSlot;
  logic [CW-1:0]     free;
  logic              memReady;
  logic              aluReady;
  logic              memPush;
  logic              aluPush;
  logic              pop;

  // Credit comes only from the registered count; a same-cycle pop is not counted.
  assign free     = DEPTH_C - count;
  assign memReady = rst & (free >= CW'(1));
  assign aluReady = rst & ((free >= CW'(2)) | ((free == CW'(1)) & ~wb.mem_valid));

  assign wb.mem_ready = memReady;
  assign wb.alu_ready = aluReady;

  // Writes to R0 finish the handshake but are dropped here.
  assign memPush = wb.mem_valid & memReady & (wb.mem_reg != '0);
  assign aluPush = wb.alu_valid & aluReady & (wb.alu_reg != '0);
  assign pop     = (count != '0);

  // The load is the older instruction, so it takes the first free slot.
  assign aluSlot = wrPtr + PW'(memPush);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PW'(memPush) + PW'(aluPush);
      rdPtr <= rdPtr + PW'(pop);
      count <= count + CW'(memPush) + CW'(aluPush) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (memPush) begin
      regArr[wrPtr]  <= wb.mem_reg;
      dataArr[wrPtr] <= wb.mem_data;
    end
    if (aluPush) begin
      regArr[aluSlot]  <= wb.alu_reg;
      dataArr[aluSlot] <= wb.alu_data;
    end
  end

  // Write port decodes registered state only; empty queue drives zeros.
  assign wb.WriteReg = pop;
  assign wb.DstReg   = pop ? regArr[rdPtr]  : '0;
  assign wb.DstData  = pop ? dataArr[rdPtr] : '0;

`ifdef WB_FWD_EN
  logic [REG_W-1:0]  ageReg  [DEPTH];
  logic [DATA_W-1:0] ageData [DEPTH];
  logic [DEPTH-1:0]  ageVld;

  // Rotate storage so index 0 is the head and higher indices are younger.
  always_comb begin
    ageVld = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ageReg[k]  = regArr[rdPtr + PW'(k)];
      ageData[k] = dataArr[rdPtr + PW'(k)];
      ageVld[k]  = (CW'(k) < count);
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(DATA_W)) uFwd1 (
    .srcReg  (SrcReg1),
    .entReg  (ageReg),
    .entData (ageData),
    .entVld  (ageVld),
    .hit     (fwd_hit1),
    .data    (fwd_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(DATA_W)) uFwd2 (
    .srcReg  (SrcReg2),
    .entReg  (ageReg),
    .entData (ageData),
    .entVld  (ageVld),
    .hit     (fwd_hit2),
    .data    (fwd_data2)
  );
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue; covers the forwarding ports when WB_FWD_EN is defined.
module tb_reg_writeback_queue;
  import wb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] count;
`ifdef WB_FWD_EN
  logic [3:0]  SrcReg1 = '0;
  logic [3:0]  SrcReg2 = '0;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [15:0] fwd_data1;
  logic [15:0] fwd_data2;
`endif

  int numChecks = 0;
  int numErrors = 0;
  wb_entry_t commits [$];
  wb_entry_t expList [$];

  reg_writeback_queue_if #(.REG_W(4), .DATA_W(16)) wb ();

  reg_writeback_queue #(.DEPTH(4), .DATA_W(16), .REG_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .wb    (wb),
    .count (count)
`ifdef WB_FWD_EN
    ,
    .SrcReg1   (SrcReg1),
    .SrcReg2   (SrcReg2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-file side: every presented write commits at the rising edge.
  always @(posedge clk) begin
    if (wb.WriteReg === 1'b1) commits.push_back({wb.DstReg, wb.DstData});
  end

  always @(negedge clk) begin
    if (rst) checkVal("count_le_depth", 32'(count <= 3'd4), 32'd1);
  end

  function automatic wb_entry_t ent(input logic [3:0] r, input logic [15:0] d);
    ent = {r, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.mem_valid = 1'b0;
    wb.mem_reg   = '0;
    wb.mem_data  = '0;
    wb.alu_valid = 1'b0;
    wb.alu_reg   = '0;
    wb.alu_data  = '0;
  endtask

  task automatic sendMem(input logic [3:0] r, input logic [15:0] d);
    wb.mem_valid = 1'b1;
    wb.mem_reg   = r;
    wb.mem_data  = d;
  endtask

  task automatic sendAlu(input logic [3:0] r, input logic [15:0] d);
    wb.alu_valid = 1'b1;
    wb.alu_reg   = r;
    wb.alu_data  = d;
  endtask

  task automatic checkCommits(input string tag);
    checkVal({tag, "_n"}, 32'(commits.size()), 32'(expList.size()));
    for (int i = 0; i < expList.size(); i++) begin
      if (i < commits.size()) begin
        checkVal($sformatf("%s_reg%0d", tag, i), 32'(commits[i].regId), 32'(expList[i].regId));
        checkVal($sformatf("%s_data%0d", tag, i), 32'(commits[i].data), 32'(expList[i].data));
      end
    end
  endtask

  logic [3:0]  mRegs [4] = '{4'd1, 4'd2, 4'd4, 4'd8};
  logic [15:0] mData [4] = '{16'h1001, 16'h1002, 16'h1003, 16'h1004};
  logic [3:0]  aRegs [4] = '{4'd9, 4'd10, 4'd11, 4'd12};
  logic [15:0] aData [4] = '{16'h2001, 16'h2002, 16'h2003, 16'h2004};

  initial begin
    int mi;
    int ai;
    int cyc;
    int maxCnt;
    logic memAcc;
    logic aluAcc;
    logic sawAluBlocked;

    idle();
    repeat (2) step();
    checkVal("rst_count", 32'(count), 32'd0);
    checkVal("rst_writereg", 32'(wb.WriteReg), 32'd0);
    checkVal("rst_dstreg", 32'(wb.DstReg), 32'd0);
    checkVal("rst_dstdata", 32'(wb.DstData), 32'd0);
    checkVal("rst_mem_ready", 32'(wb.mem_ready), 32'd0);
    checkVal("rst_alu_ready", 32'(wb.alu_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkVal("idle_mem_ready", 32'(wb.mem_ready), 32'd1);
    checkVal("idle_alu_ready", 32'(wb.alu_ready), 32'd1);

    // Single ALU write
    commits.delete();
    sendAlu(4'd3, 16'h1234);
    step();
    idle();
    checkVal("alu_writereg", 32'(wb.WriteReg), 32'd1);
    checkVal("alu_dstreg", 32'(wb.DstReg), 32'd3);
    checkVal("alu_dstdata", 32'(wb.DstData), 32'h1234);
    checkVal("alu_count", 32'(count), 32'd1);
    step();
    checkVal("alu_empty_count", 32'(count), 32'd0);
    checkVal("alu_empty_writereg", 32'(wb.WriteReg), 32'd0);
    expList.delete();
    expList.push_back(ent(4'd3, 16'h1234));
    checkCommits("alu_commit");

    // Same-cycle mem and ALU
    commits.delete();
    sendMem(4'd5, 16'hAAAA);
    sendAlu(4'd6, 16'h5555);
    step();
    idle();
    checkVal("pair_count", 32'(count), 32'd2);
    checkVal("pair_head_reg", 32'(wb.DstReg), 32'd5);
    checkVal("pair_head_data", 32'(wb.DstData), 32'hAAAA);
    step();
    checkVal("pair_count1", 32'(count), 32'd1);
    checkVal("pair_second_reg", 32'(wb.DstReg), 32'd6);
    checkVal("pair_second_data", 32'(wb.DstData), 32'h5555);
    step();
    checkVal("pair_count0", 32'(count), 32'd0);
    expList.delete();
    expList.push_back(ent(4'd5, 16'hAAAA));
    expList.push_back(ent(4'd6, 16'h5555));
    checkCommits("pair_commit");

    // Both producers streaming: mem wins the last slot, ALU waits
    commits.delete();
    mi = 0;
    ai = 0;
    cyc = 0;
    maxCnt = 0;
    sawAluBlocked = 1'b0;
    while ((mi < 4 || ai < 4) && cyc < 40) begin
      idle();
      if (mi < 4) sendMem(mRegs[mi], mData[mi]);
      if (ai < 4) sendAlu(aRegs[ai], aData[ai]);
      #1;
      memAcc = wb.mem_valid & wb.mem_ready;
      aluAcc = wb.alu_valid & wb.alu_ready;
      if (wb.alu_valid && !wb.alu_ready) sawAluBlocked = 1'b1;
      step();
      if (memAcc) mi++;
      if (aluAcc) ai++;
      if (int'(count) > maxCnt) maxCnt = int'(count);
      cyc++;
    end
    idle();
    checkVal("stream_all_accepted", 32'((mi == 4) && (ai == 4)), 32'd1);
    checkVal("stream_peak_count", 32'(maxCnt), 32'd3);
    checkVal("stream_alu_backpressure", 32'(sawAluBlocked), 32'd1);
    repeat (6) step();
    checkVal("stream_drained", 32'(count), 32'd0);
    expList.delete();
    expList.push_back(ent(4'd1,  16'h1001));
    expList.push_back(ent(4'd9,  16'h2001));
    expList.push_back(ent(4'd2,  16'h1002));
    expList.push_back(ent(4'd10, 16'h2002));
    expList.push_back(ent(4'd4,  16'h1003));
    expList.push_back(ent(4'd8,  16'h1004));
    expList.push_back(ent(4'd11, 16'h2003));
    expList.push_back(ent(4'd12, 16'h2004));
    checkCommits("stream_commit");

    // Writes to R0 are accepted and dropped
    commits.delete();
    sendMem(4'd0, 16'hFFFF);
    sendAlu(4'd0, 16'hFFFF);
    #1;
    checkVal("r0_mem_ready", 32'(wb.mem_ready), 32'd1);
    checkVal("r0_alu_ready", 32'(wb.alu_ready), 32'd1);
    step();
    idle();
    checkVal("r0_count", 32'(count), 32'd0);
    checkVal("r0_writereg", 32'(wb.WriteReg), 32'd0);
    step();
    checkVal("r0_writereg_later", 32'(wb.WriteReg), 32'd0);
    checkVal("r0_no_commit", 32'(commits.size()), 32'd0);

`ifdef WB_FWD_EN
    // Forwarding picks the youngest matching entry
    sendMem(4'd7, 16'h0001);
    sendAlu(4'd7, 16'h0002);
    step();
    idle();
    SrcReg1 = 4'd7;
    SrcReg2 = 4'd0;
    #1;
    checkVal("fwd_hit1", 32'(fwd_hit1), 32'd1);
    checkVal("fwd_data1", 32'(fwd_data1), 32'h0002);
    checkVal("fwd_hit2_r0", 32'(fwd_hit2), 32'd0);
    checkVal("fwd_data2_r0", 32'(fwd_data2), 32'd0);
    SrcReg1 = 4'd9;
    #1;
    checkVal("fwd_miss_hit", 32'(fwd_hit1), 32'd0);
    checkVal("fwd_miss_data", 32'(fwd_data1), 32'd0);
    SrcReg1 = 4'd0;
    repeat (3) step();
`endif

    // Reset with three writes pending
    commits.delete();
    sendMem(4'd1, 16'h0A01);
    sendAlu(4'd2, 16'h0A02);
    step();
    sendMem(4'd3, 16'h0A03);
    sendAlu(4'd4, 16'h0A04);
    step();
    idle();
    checkVal("flush_pending", 32'(count), 32'd3);
    rst = 1'b0;
    #1;
    checkVal("flush_mem_ready_low", 32'(wb.mem_ready), 32'd0);
    checkVal("flush_alu_ready_low", 32'(wb.alu_ready), 32'd0);
    step();
    commits.delete();
    checkVal("flush_count", 32'(count), 32'd0);
    checkVal("flush_writereg", 32'(wb.WriteReg), 32'd0);
    checkVal("flush_dstreg", 32'(wb.DstReg), 32'd0);
    rst = 1'b1;
    repeat (4) step();
    checkVal("flush_no_commit", 32'(commits.size()), 32'd0);
    checkVal("flush_writereg_later", 32'(wb.WriteReg), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
